axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3 slave (responder) backed by an on-chip word-addressed memory array. It sits on the far side of the CPU's single AXI master port and serves icache/dcache line-fill bursts and dcache write-backs. It is the memory endpoint for core-level simulation and FPGA bring-up without the SoC. Reads and writes run on independent channel FSMs, with one outstanding transaction per direction.

## Interface
- MEM_AW, 14: word-index width; depth = 2^MEM_AW 32-bit words (64 KiB).
- BASE_ADDR, 32'h1FC0_0000: byte address mapped to word 0.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- arid, araddr, arlen, arsize, arburst  input  4/32/8/3/2  read address payload.
- arlock, arcache, arprot  input  2/4/3  accepted, ignored.
- arvalid / arready  input / output  1 / 1  read address handshake.
- rid, rdata, rresp, rlast  output  4/32/2/1  read data payload.
- rvalid / rready  output / input  1 / 1  read data handshake.
- awid, awaddr, awlen, awsize, awburst  input  4/32/8/3/2  write address payload.
- awlock, awcache, awprot  input  2/4/3  accepted, ignored.
- awvalid / awready  input / output  1 / 1  write address handshake.
- wid, wdata, wstrb, wlast  input  4/32/4/1  write data; wid is ignored (no interleaving).
- wvalid / wready  input / output  1 / 1  write data handshake.
- bid, bresp  output  4/2  write response.
- bvalid / bready  output / input  1 / 1  write response handshake.

## Operation
- Read FSM has two states, R_IDLE and R_BURST.
  - R_IDLE: arready=1. On arvalid the FSM latches id, addr, len, size and burst, clears beat_cnt, and moves to R_BURST.
  - R_BURST: rvalid=1, rdata=mem[addr word index], rid=latched id, rlast=(beat_cnt==len). Each rvalid&rready advances addr and increments beat_cnt. Completion on rlast: R_IDLE.
- Write FSM has three states, W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On accept it latches the fields and moves to W_DATA.
  - W_DATA: wready=1. Each wvalid handshake writes mem bytes enabled by wstrb, then advances addr and beat_cnt. wvalid&wlast moves to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. bready returns the FSM to W_IDLE.
- bresp=OKAY. If wlast arrives at beat_cnt!=awlen, bresp=SLVERR (2'b10).
- W beats presented before AW is accepted are not consumed; wready=0 outside W_DATA.
- Address advance, with bytes=1<<min(size,2) (size>2 is treated as 2):
  - FIXED: addr unchanged.
  - INCR: addr+bytes.
  - WRAP: mask=(len+1)*bytes-1; addr=(addr&~mask)|((addr+bytes)&mask).
  - Reserved burst type (2'b11): treated as INCR.
- Word index = (addr-BASE_ADDR)[MEM_AW+1:2]. Out-of-range addresses wrap modulo depth (see Configuration).
- Simultaneous read and write of the same word in the same cycle: the read returns the old data and the write lands at the edge.

## Timing
- Reset state: both FSMs idle; arready=1, awready=1. rvalid, rlast, wready, bvalid, rresp and bresp are 0; rid and bid are 0.
- AR handshake at edge T gives first rvalid in cycle T+1. With rready held high, a burst of N beats completes in N cycles. arready returns 1 in the cycle after the rlast handshake.
- AW handshake at T gives wready=1 in T+1. The wlast handshake at T' gives bvalid=1 in T'+1. awready returns 1 in the cycle after the bready handshake.
- rdata/rid/rlast are stable while rvalid=1 and rready=0. bid/bresp are stable while bvalid=1 and bready=0.
- Reset asserted mid-burst: both FSMs abort to idle on that edge. Memory contents are preserved; there is no response for the aborted transaction.
- beat_cnt is 8 bits, so len=255 (256 beats) must terminate correctly without overflow.

## Configuration
- AXI_SLAVE_DECERR_EN defined: an address outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AW) on any beat behaves as follows.
  - Reads: that beat returns rresp=DECERR (2'b11) and rdata=0.
  - Writes: the beat is dropped, and bresp=DECERR for the whole burst; DECERR has priority over SLVERR.
- Undefined: addresses wrap modulo depth and responses are OKAY/SLVERR only.

## Structure
- A shared package axi_pkg holds the burst enum (FIXED/INCR/WRAP), response constants (OKAY/EXOKAY/SLVERR/DECERR), and the read and write FSM state enums.
- One sub-module, axi_burst_addr_gen, is combinational next-address logic taking (addr, len, size, burst); it is instantiated once per channel.
- The memory array and both FSMs live in axi_sram_slave.

## Test plan
- Preload mem[0..7]=i. INCR read araddr=BASE, arlen=7, arsize=2, rready=1 -> 8 beats with data 0..7, rlast only on beat 8, rresp=0, rid echoes arid=4'h3.
- WRAP read araddr=BASE+0x18, arlen=3 -> data words 6,7,4,5; rlast on the 4th beat.
- INCR write of 4 beats, wdata=A0..A3, the 2nd beat with wstrb=4'b0011 over 0xFFFFFFFF -> readback shows 0xFFFF and A0/A2/A3 intact; bresp=OKAY, bid=awid.
- Write with awlen=3 and wlast on beat 2 -> bresp=2'b10; the next AW is accepted after bready.
- rready toggling 1010… during an 8-beat read -> rdata held while stalled, 8 unique beats delivered. Reset asserted at beat 3 -> rvalid=0 and arready=1 the next cycle.
- AXI_SLAVE_DECERR_EN: read araddr=BASE+4*2^MEM_AW -> rresp=2'b11 and rdata=0. Write to that address -> bresp=2'b11 and memory unchanged.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3 types for the SRAM slave.
// Burst codes, response codes and channel FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Sizes above 4 bytes clamp to 4; reserved burst type acts as INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [2:0]  sz;
  logic [31:0] bytes;
  logic [31:0] mask;
  logic [31:0] inc;

  // beat stride, wrap window and the next address
  always_comb begin
    sz    = (size > 3'd2) ? 3'd2 : size;
    bytes = 32'd1 << sz;
    mask  = (({24'd0, len} + 32'd1) << sz) - 32'd1;
    inc   = addr + bytes;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a 32-bit word memory; one burst per direction.
// Option: AXI_SLAVE_DECERR_EN makes out-of-window beats DECERR.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 2 ** MEM_AW;

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic [31:0] r_next;
  logic [31:0] r_off;
  logic [MEM_AW-1:0] r_idx;
  logic        r_oor;

  w_state_t    w_state;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [7:0]  w_cnt;
  logic [31:0] w_next;
  logic [31:0] w_off;
  logic [MEM_AW-1:0] w_idx;
  logic        w_oor;
  logic        w_slv;
  logic        w_dec;
  logic        w_fire;
  logic        w_en;

  logic        unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot,
                       awlock, awcache, awprot,
                       wid, r_off, w_off, r_oor, w_oor};

  axi_burst_addr_gen u_r_gen (
    .addr      (r_addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  axi_burst_addr_gen u_w_gen (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  assign r_off = r_addr - BASE_ADDR;
  assign r_idx = r_off[MEM_AW+1:2];
  assign r_oor = |r_off[31:MEM_AW+2];
  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = w_off[MEM_AW+1:2];
  assign w_oor = |w_off[31:MEM_AW+2];

  // read channel: accept AR, then stream beats until rlast handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_id    <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          r_state <= R_BURST;
        end
        R_BURST: if (rready) begin
          r_addr <= r_next;
          r_cnt  <= r_cnt + 8'd1;
          if (r_cnt == r_len) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_BURST);
  assign rid     = r_id;
  assign rlast   = rvalid && (r_cnt == r_len);

`ifdef AXI_SLAVE_DECERR_EN
  assign rdata = r_oor ? 32'd0 : mem[r_idx];
  assign rresp = (rvalid && r_oor) ? RESP_DECERR : RESP_OKAY;
  assign w_en  = w_fire && !w_oor;
`else
  assign rdata = mem[r_idx];
  assign rresp = RESP_OKAY;
  assign w_en  = w_fire;
`endif

  assign w_fire = rst && (w_state == W_DATA) && wvalid;

  // write channel: accept AW, absorb beats to wlast, then respond
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_slv   <= 1'b0;
      w_dec   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_slv   <= 1'b0;
          w_dec   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_next;
          w_cnt  <= w_cnt + 8'd1;
`ifdef AXI_SLAVE_DECERR_EN
          if (w_oor) w_dec <= 1'b1;
`endif
          if (wlast) begin
            if (w_cnt != w_len) w_slv <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = w_id;

  // response code, decode error outranks short-burst error
  always_comb begin
    bresp = RESP_OKAY;
    if (bvalid) begin
      if (w_dec)      bresp = RESP_DECERR;
      else if (w_slv) bresp = RESP_SLVERR;
    end
  end

  // byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave.
// Read table plus hand sequences for writes, errors and reset.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam logic [31:0] BASE = 32'h1FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk     (clk),
    .rst     (rst),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arlock  (2'b00),
    .arcache (4'h0),
    .arprot  (3'h0),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awlock  (2'b00),
    .awcache (4'h0),
    .awprot  (3'h0),
    .awvalid (awvalid),
    .awready (awready),
    .wid     (4'h0),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    bit               toggle;
    logic [7:0][31:0] exp;
    int               nchk;
  } rvec_t;

  rvec_t rv [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] w8(
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] a2, input logic [31:0] a3,
    input logic [31:0] a4, input logic [31:0] a5,
    input logic [31:0] a6, input logic [31:0] a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  task automatic do_read(input string nm,
                         input logic [3:0] id,
                         input logic [31:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic [1:0] burst,
                         input bit toggle,
                         input logic [7:0][31:0] exp,
                         input int nchk,
                         input logic [1:0] eresp);
    int beats;
    int cyc;
    bit ph;
    bit stalled;
    logic [31:0] hold;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len;
    arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!arready) begin
      chk({nm, "_ar_timeout"}, 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    chk({nm, "_r_latency"}, {31'd0, rvalid}, 32'd1);
    beats = 0; cyc = 0; ph = 1'b1; stalled = 1'b0;
    hold = '0;
    while (beats < int'(len) + 1 && cyc < 2000) begin
      rready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (stalled)
        chk({nm, "_stall_hold"}, rdata, hold);
      if (rvalid && rready) begin
        if (beats < nchk)
          chk($sformatf("%s_data%0d", nm, beats),
              rdata, exp[beats]);
        chk($sformatf("%s_last%0d", nm, beats),
            {31'd0, rlast}, {31'd0, beats == int'(len)});
        chk($sformatf("%s_rid%0d", nm, beats),
            {28'd0, rid}, {28'd0, id});
        chk($sformatf("%s_resp%0d", nm, beats),
            {30'd0, rresp}, {30'd0, eresp});
        beats++;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1;
        hold = rdata;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk({nm, "_beats"}, beats, int'(len) + 1);
    chk({nm, "_arready_back"}, {31'd0, arready}, 32'd1);
  endtask

  task automatic do_write(input string nm,
                          input logic [3:0] id,
                          input logic [31:0] addr,
                          input logic [7:0] len,
                          input int nbeats,
                          input logic [7:0][31:0] data,
                          input logic [7:0][3:0] strb,
                          input logic [1:0] eresp,
                          input int bdelay);
    int cyc;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len;
    awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!awready) begin
      chk({nm, "_aw_timeout"}, 32'd0, 32'd1);
      awvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    chk({nm, "_w_latency"}, {31'd0, wready}, 32'd1);
    for (int b = 0; b < nbeats; b++) begin
      wdata = data[b]; wstrb = strb[b];
      wlast = (b == nbeats - 1); wvalid = 1'b1;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk({nm, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({nm, "_bid"}, {28'd0, bid}, {28'd0, id});
    chk({nm, "_bresp"}, {30'd0, bresp}, {30'd0, eresp});
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      chk({nm, "_bhold"}, {26'd0, bvalid, bid, bresp},
          {26'd0, 1'b1, id, eresp});
      chk({nm, "_aw_blocked"}, {31'd0, awready}, 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({nm, "_awready_back"}, {31'd0, awready}, 32'd1);
    chk({nm, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] d;
    logic [7:0][3:0]  s;
    logic [1:0]       dec;
    int cyc;
    int beats;
    rst = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, arready, awready}, 32'd3);
    chk("rst_valid", {29'd0, rvalid, wready, bvalid}, 32'd0);
    chk("rst_ids", {24'd0, rid, bid}, 32'd0);
    chk("rst_resp", {27'd0, rresp, bresp, rlast}, 32'd0);
    rst = 1'b1;

    // W beats ahead of AW must not be taken
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF;
    wstrb = 4'hF; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_before_aw", {31'd0, wready}, 32'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    d = w8(0, 1, 2, 3, 4, 5, 6, 7);
    s = {8{4'hF}};
    do_write("preload", 4'h1, BASE, 8'd7, 8, d, s,
             RESP_OKAY, 0);
    d = w8(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    do_write("ones", 4'h2, BASE + 32'h24, 8'd0, 1, d, s,
             RESP_OKAY, 0);
    d = w8(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0);
    s[1] = 4'b0011;
    do_write("strb", 4'h9, BASE + 32'h20, 8'd3, 4, d, s,
             RESP_OKAY, 2);
    s = {8{4'hF}};
    do_write("short", 4'h4, BASE + 32'h40, 8'd3, 2, d, s,
             RESP_SLVERR, 1);
    d = w8(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    do_write("after_err", 4'h5, BASE + 32'h44, 8'd0, 1, d,
             s, RESP_OKAY, 0);

    rv[0] = '{4'h3, BASE, 8'd7, 3'd2, BURST_INCR, 1'b0,
              w8(0, 1, 2, 3, 4, 5, 6, 7), 8};
    rv[1] = '{4'h5, BASE + 32'h18, 8'd3, 3'd2, BURST_WRAP,
              1'b0, w8(6, 7, 4, 5, 0, 0, 0, 0), 4};
    rv[2] = '{4'h1, BASE + 32'h8, 8'd3, 3'd2, BURST_FIXED,
              1'b0, w8(2, 2, 2, 2, 0, 0, 0, 0), 4};
    rv[3] = '{4'h2, BASE + 32'h4, 8'd1, 3'd2, BURST_INCR,
              1'b0, w8(1, 2, 0, 0, 0, 0, 0, 0), 2};
    rv[4] = '{4'h6, BASE + 32'h4, 8'd1, 3'd2, BURST_WRAP,
              1'b0, w8(1, 0, 0, 0, 0, 0, 0, 0), 2};
    rv[5] = '{4'h7, BASE + 32'h10, 8'd2, 3'd2, 2'b11,
              1'b0, w8(4, 5, 6, 0, 0, 0, 0, 0), 3};
    rv[6] = '{4'h8, BASE, 8'd2, 3'd3, BURST_INCR,
              1'b0, w8(0, 1, 2, 0, 0, 0, 0, 0), 3};
    rv[7] = '{4'h9, BASE, 8'd1, 3'd0, BURST_INCR,
              1'b0, w8(0, 0, 0, 0, 0, 0, 0, 0), 2};
    rv[8] = '{4'hA, BASE + 32'h20, 8'd3, 3'd2, BURST_INCR,
              1'b0, w8(32'hA0, 32'hFFFF_00A1, 32'hA2,
                       32'hA3, 0, 0, 0, 0), 4};
    rv[9] = '{4'hB, BASE, 8'd7, 3'd2, BURST_INCR, 1'b1,
              w8(0, 1, 2, 3, 4, 5, 6, 7), 8};

    for (int v = 0; v < 10; v++)
      do_read($sformatf("rd%0d", v), rv[v].id, rv[v].addr,
              rv[v].len, rv[v].size, rv[v].burst,
              rv[v].toggle, rv[v].exp, rv[v].nchk,
              RESP_OKAY);

    d = w8(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    do_read("short_rb", 4'h0, BASE + 32'h44, 8'd0, 3'd2,
            BURST_INCR, 1'b0, d, 1, RESP_OKAY);

    do_read("len255", 4'hC, BASE, 8'd255, 3'd2,
            BURST_INCR, 1'b0, w8(0, 1, 2, 3, 4, 5, 6, 7), 8,
            RESP_OKAY);

    // reset in the middle of a read burst
    @(negedge clk);
    arid = 4'hD; araddr = BASE; arlen = 8'd7;
    arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0;
    rready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 50) begin
      @(negedge clk);
      if (rvalid) beats++;
      cyc++;
    end
    chk("rst_mid_beats", beats, 3);
    rready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_mid_arready", {31'd0, arready}, 32'd1);
    chk("rst_mid_rid", {27'd0, rid, rlast}, 32'd0);
    rst = 1'b1;
    do_read("post_rst", 4'h1, BASE + 32'hC, 8'd0, 3'd2,
            BURST_INCR, 1'b0, w8(3, 0, 0, 0, 0, 0, 0, 0), 1,
            RESP_OKAY);

    // one word past the window: wraps, or DECERR when enabled
`ifdef AXI_SLAVE_DECERR_EN
    dec = RESP_DECERR;
`else
    dec = RESP_OKAY;
`endif
    do_read("oor_rd", 4'hE, BASE + 32'h1_0000, 8'd0, 3'd2,
            BURST_INCR, 1'b0, w8(0, 0, 0, 0, 0, 0, 0, 0), 1,
            dec);
    d = w8(32'h55, 0, 0, 0, 0, 0, 0, 0);
    do_write("oor_wr", 4'hF, BASE + 32'h1_0000, 8'd0, 1, d,
             s, dec, 0);
`ifdef AXI_SLAVE_DECERR_EN
    d = w8(0, 0, 0, 0, 0, 0, 0, 0);
`endif
    do_read("oor_chk", 4'h2, BASE, 8'd0, 3'd2, BURST_INCR,
            1'b0, d, 1, RESP_OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
